// File: rtl/mul_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_arbiter_if
// Description : Requester, multiplier and response signals of mul_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int SIZE1 = 4,
    parameter int SIZE2 = 4
);
    localparam int c_IDW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*SIZE1-1:0] req_a;
    logic [NREQ*SIZE2-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_en;
    logic [SIZE1-1:0]      mul_a;
    logic [SIZE2-1:0]      mul_b;
    logic [SIZE1+SIZE2-1:0] mul_y;
    logic                  rsp_valid;
    logic [c_IDW-1:0]      rsp_id;
    logic [SIZE1+SIZE2-1:0] rsp_y;
    logic                  busy;
    logic [3:0]            inflight;

    modport slave (
        input  req_valid, req_a, req_b, req_en, mul_y,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_y, busy, inflight
    );

    modport master (
        output req_valid, req_a, req_b, req_en, mul_y,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_y, busy, inflight
    );
endinterface
`default_nettype wire

// File: rtl/mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mul_arbiter
// Description : Round-robin issue arbiter sharing one pipelined multiplier,
//               returning each product tagged with its requester index.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_arbiter #(
    parameter int NREQ  = 2,
    parameter int STAGE = 1,
    parameter int SIZE1 = 4,
    parameter int SIZE2 = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mul_arbiter_if.slave bus
);
    localparam int c_IDW = (NREQ > 2) ? $clog2(NREQ) : 1;
    localparam int c_YW  = SIZE1 + SIZE2;
    localparam logic [c_IDW-1:0] c_LAST_ID = c_IDW'(NREQ - 1);

    logic [NREQ-1:0]  w_elig;
    logic [NREQ-1:0]  w_upper;
    logic [NREQ-1:0]  w_pick;
    logic [NREQ-1:0]  w_grant;
    logic [c_IDW-1:0] w_gid;
    logic             w_xfer;
    logic [SIZE1-1:0] w_a;
    logic [SIZE2-1:0] w_b;

    logic [c_IDW-1:0] r_ptr;
    logic [SIZE1-1:0] r_mul_a;
    logic [SIZE2-1:0] r_mul_b;
    logic             r_tag_v  [STAGE];
    logic [c_IDW-1:0] r_tag_id [STAGE];
    logic             r_rsp_valid;
    logic [c_IDW-1:0] r_rsp_id;
    logic [c_YW-1:0]  r_rsp_y;
    logic [3:0]       r_inflight;

    assign w_elig = bus.req_valid & bus.req_en;

    // Prefer eligible requesters at or above ptr; fall back to the lowest
    // eligible index, which realises the upward search with wrap.
    always_comb begin : p_arb
        w_upper = '0;
        w_grant = '0;
        w_gid   = '0;
        w_xfer  = 1'b0;
        w_a     = '0;
        w_b     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_upper[k] = (k >= int'(r_ptr));
        end
        w_pick = ((w_elig & w_upper) != '0) ? (w_elig & w_upper) : w_elig;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_xfer && w_pick[k]) begin
                w_xfer     = 1'b1;
                w_gid      = c_IDW'(k);
                w_grant[k] = 1'b1;
                w_a        = bus.req_a[k*SIZE1 +: SIZE1];
                w_b        = bus.req_b[k*SIZE2 +: SIZE2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_issue
        if (!rst_n) begin
            r_ptr   <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else if (w_xfer) begin
            r_ptr   <= (w_gid == c_LAST_ID) ? '0 : w_gid + c_IDW'(1);
            r_mul_a <= w_a;
            r_mul_b <= w_b;
        end
    end

    // Tag stage STAGE-1 lines up with the product of its operands on mul_y.
    always_ff @(posedge clk or negedge rst_n) begin : p_tags
        if (!rst_n) begin
            for (int k = 0; k < STAGE; k++) begin
                r_tag_v[k]  <= 1'b0;
                r_tag_id[k] <= '0;
            end
        end else begin
            r_tag_v[0]  <= w_xfer;
            r_tag_id[0] <= w_gid;
            for (int k = 1; k < STAGE; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_rsp
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_y     <= '0;
        end else begin
            r_rsp_valid <= r_tag_v[STAGE-1];
            r_rsp_id    <= r_tag_id[STAGE-1];
            if (r_tag_v[STAGE-1]) begin
                r_rsp_y <= bus.mul_y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_count
        if (!rst_n) begin
            r_inflight <= 4'd0;
        end else begin
            case ({w_xfer, r_rsp_valid})
                2'b10:   r_inflight <= r_inflight + 4'd1;
                2'b01:   r_inflight <= r_inflight - 4'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_y     = r_rsp_y;
    assign bus.inflight  = r_inflight;
    assign bus.busy      = (r_inflight != 4'd0);
endmodule
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_arbiter
// Description : Self-checking bench for mul_arbiter with a pipelined mul model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_arbiter;
    localparam int NREQ  = 3;
    localparam int STAGE = 4;
    localparam int SW    = 8;

    typedef struct {
        int due;
        int id;
        int y;
    } rsp_t;

    logic clk;
    logic rst_n;

    mul_arbiter_if #(.NREQ(NREQ), .SIZE1(SW), .SIZE2(SW)) bus ();

    mul_arbiter #(.NREQ(NREQ), .STAGE(STAGE), .SIZE1(SW), .SIZE2(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Requester-side stimulus
    logic [NREQ-1:0] v_in;
    logic [NREQ-1:0] en_in;
    logic [SW-1:0]   a_in [NREQ];
    logic [SW-1:0]   b_in [NREQ];

    assign bus.req_valid = v_in;
    assign bus.req_en    = en_in;
    assign bus.req_a     = {a_in[2], a_in[1], a_in[0]};
    assign bus.req_b     = {b_in[2], b_in[1], b_in[0]};

    // Multiplier without reset: STAGE-1 product registers behind mul_a/mul_b
    logic [2*SW-1:0] p_pipe [STAGE-1];
    always @(posedge clk) begin
        p_pipe[0] <= 16'(bus.mul_a) * 16'(bus.mul_b);
        for (int k = 1; k < STAGE - 1; k++) p_pipe[k] <= p_pipe[k-1];
    end
    assign bus.mul_y = p_pipe[STAGE-2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int              total;
    int              bad;
    int              cyc;
    int              m_ptr;
    rsp_t            q[$];
    logic [SW-1:0]   m_a;
    logic [SW-1:0]   m_b;
    logic [2*SW-1:0] m_y;
    logic [NREQ-1:0] obs_ready;
    logic [NREQ-1:0] exp_ready;
    logic            exp_rv;
    int              exp_id;
    int              exp_inf;
    int              last_g;

    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (v_in[i] && en_in[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_ptr = 0;
        m_a   = '0;
        m_b   = '0;
        m_y   = '0;
    endfunction

    // One clock: sample the grant mid-cycle, advance the model at the edge,
    // and leave the expectations for the cycle after the edge.
    task automatic tick();
        int g;
        @(negedge clk);
        g         = model_grant();
        obs_ready = bus.req_ready;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        last_g = g;
        @(posedge clk);
        cyc++;
        if (g >= 0) begin
            q.push_back('{cyc + STAGE, g, int'(a_in[g]) * int'(b_in[g])});
            m_ptr = (g + 1) % NREQ;
            m_a   = a_in[g];
            m_b   = b_in[g];
        end
        #1;
        exp_inf = q.size();
        exp_rv  = 1'b0;
        exp_id  = 0;
        if (q.size() != 0 && q[0].due == cyc) begin
            exp_rv = 1'b1;
            exp_id = q[0].id;
            m_y    = 16'(q[0].y);
            void'(q.pop_front());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v_in  = 3'b110;
        en_in = 3'b111;
        #3;
        total++;
        if (bus.req_ready !== 3'b010) begin
            bad++; $display("FAIL reset_ready: got %b want 010", bus.req_ready);
        end
        total++;
        if (bus.mul_a !== 8'd0 || bus.mul_b !== 8'd0 || bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 ||
            bus.rsp_y !== 16'd0 || bus.inflight !== 4'd0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: got a=%h b=%h rv=%b id=%h y=%h inf=%h busy=%b want all zero",
                            bus.mul_a, bus.mul_b, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.inflight, bus.busy);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.req_ready !== 3'b010 || bus.inflight !== 4'd0 || bus.mul_a !== 8'd0) begin
            bad++; $display("FAIL reset_hold: got ready=%b inf=%h a=%h want 010 0 00",
                            bus.req_ready, bus.inflight, bus.mul_a);
        end
        v_in = '0;
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        int    req [2] = '{1, 0};
        int    av  [2] = '{13, 255};
        int    bv  [2] = '{11, 255};
        int    yv  [2] = '{143, 65025};
        int    lat;
        string nm;
        nm = "single";
        for (int c = 0; c < 2; c++) begin
            v_in         = '0;
            a_in[req[c]] = 8'(av[c]);
            b_in[req[c]] = 8'(bv[c]);
            v_in[req[c]] = 1'b1;
            lat          = -1;
            for (int t = 0; t <= STAGE + 3; t++) begin
                tick();
                if (t == 0) begin
                    v_in = '0;
                    total++;
                    if (obs_ready !== 3'(1 << req[c])) begin
                        bad++; $display("FAIL %s_grant: got %b want %b", nm, obs_ready, 3'(1 << req[c]));
                    end
                end
                total++;
                if (obs_ready !== exp_ready) begin bad++; $display("FAIL %s_ready: got %b want %b", nm, obs_ready, exp_ready); end
                total++;
                if (bus.rsp_valid !== exp_rv) begin bad++; $display("FAIL %s_rsp_valid: got %b want %b", nm, bus.rsp_valid, exp_rv); end
                total++;
                if (bus.inflight !== 4'(exp_inf) || bus.busy !== (exp_inf != 0)) begin
                    bad++; $display("FAIL %s_inflight: got %0d/%b want %0d", nm, bus.inflight, bus.busy, exp_inf);
                end
                total++;
                if (bus.mul_a !== m_a || bus.mul_b !== m_b) begin
                    bad++; $display("FAIL %s_mul_ops: got %h,%h want %h,%h", nm, bus.mul_a, bus.mul_b, m_a, m_b);
                end
                if (bus.rsp_valid === 1'b1 && lat < 0) begin
                    lat = t;
                    total++;
                    if (bus.rsp_y !== 16'(yv[c]) || bus.rsp_id !== 2'(req[c])) begin
                        bad++; $display("FAIL %s_product: got id=%0d y=%0d want id=%0d y=%0d",
                                        nm, bus.rsp_id, bus.rsp_y, req[c], yv[c]);
                    end
                end
            end
            total++;
            if (lat != STAGE) begin bad++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, STAGE); end
        end
    endtask

    task automatic test_contention();
        int    start;
        string nm;
        nm    = "contend";
        start = m_ptr;
        v_in  = 3'b111;
        en_in = 3'b111;
        for (int i = 0; i < NREQ; i++) begin
            a_in[i] = 8'($urandom); b_in[i] = 8'($urandom);
        end
        for (int t = 0; t < 9 + STAGE + 1; t++) begin
            if (t == 9) v_in = '0;
            tick();
            if (t < 9) begin
                a_in[last_g] = 8'($urandom); b_in[last_g] = 8'($urandom);
                total++;
                if (obs_ready !== 3'(1 << ((start + t) % NREQ))) begin
                    bad++; $display("FAIL %s_rotation: got %b want %b", nm, obs_ready, 3'(1 << ((start + t) % NREQ)));
                end
            end
            if (t >= STAGE && t < 9 + STAGE) begin
                total++;
                if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL %s_no_bubble: got %b want 1", nm, bus.rsp_valid); end
            end
            total++;
            if (bus.rsp_valid !== exp_rv) begin bad++; $display("FAIL %s_rsp_valid: got %b want %b", nm, bus.rsp_valid, exp_rv); end
            if (exp_rv) begin
                total++;
                if (bus.rsp_id !== 2'(exp_id) || bus.rsp_y !== m_y) begin
                    bad++; $display("FAIL %s_rsp: got id=%0d y=%0d want id=%0d y=%0d", nm, bus.rsp_id, bus.rsp_y, exp_id, m_y);
                end
            end
            total++;
            if (bus.inflight !== 4'(exp_inf) || bus.busy !== (exp_inf != 0)) begin
                bad++; $display("FAIL %s_inflight: got %0d/%b want %0d", nm, bus.inflight, bus.busy, exp_inf);
            end
        end
    endtask

    task automatic test_mask();
        string nm;
        nm    = "mask";
        v_in  = 3'b111;
        en_in = 3'b001;
        for (int t = 0; t < 7; t++) begin
            if (t == 6) en_in = 3'b111;
            tick();
            total++;
            if (obs_ready !== ((t == 6) ? 3'b010 : 3'b001)) begin
                bad++; $display("FAIL %s_grant: got %b want %b", nm, obs_ready, (t == 6) ? 3'b010 : 3'b001);
            end
            total++;
            if (obs_ready !== exp_ready) begin bad++; $display("FAIL %s_ready: got %b want %b", nm, obs_ready, exp_ready); end
            total++;
            if (bus.mul_a !== m_a || bus.mul_b !== m_b) begin
                bad++; $display("FAIL %s_mul_ops: got %h,%h want %h,%h", nm, bus.mul_a, bus.mul_b, m_a, m_b);
            end
        end
        v_in = '0;
        while (q.size() != 0) begin
            tick();
            total++;
            if (bus.rsp_valid !== exp_rv || (exp_rv && (bus.rsp_id !== 2'(exp_id) || bus.rsp_y !== m_y))) begin
                bad++; $display("FAIL %s_drain: got rv=%b id=%0d y=%0d want rv=%b id=%0d y=%0d",
                                nm, bus.rsp_valid, bus.rsp_id, bus.rsp_y, exp_rv, exp_id, m_y);
            end
        end
    endtask

    task automatic test_wrap();
        logic [NREQ-1:0] want [4] = '{3'b100, 3'b001, 3'b010, 3'b100};
        string nm;
        nm    = "wrap";
        en_in = 3'b111;
        v_in  = 3'b100;
        for (int t = 0; t < 4; t++) begin
            tick();
            v_in = 3'b111;
            total++;
            if (obs_ready !== want[t]) begin bad++; $display("FAIL %s_grant%0d: got %b want %b", nm, t, obs_ready, want[t]); end
        end
        v_in = '0;
        while (q.size() != 0) begin
            tick();
            total++;
            if (bus.rsp_valid !== exp_rv || (exp_rv && (bus.rsp_id !== 2'(exp_id) || bus.rsp_y !== m_y))) begin
                bad++; $display("FAIL %s_drain: got rv=%b id=%0d y=%0d want rv=%b id=%0d y=%0d",
                                nm, bus.rsp_valid, bus.rsp_id, bus.rsp_y, exp_rv, exp_id, m_y);
            end
        end
    endtask

    task automatic test_reset_midflight();
        string nm;
        nm    = "midrst";
        en_in = 3'b111;
        v_in  = 3'b001;
        for (int t = 0; t < 4; t++) begin
            a_in[0] = 8'(20 + t); b_in[0] = 8'(3 + t);
            if (t == 3) v_in = '0;
            tick();
            total++;
            if (bus.inflight !== 4'(exp_inf)) begin bad++; $display("FAIL %s_fill: got %0d want %0d", nm, bus.inflight, exp_inf); end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.inflight !== 4'd0 || bus.busy !== 1'b0 || bus.mul_a !== 8'd0 || bus.mul_b !== 8'd0 || bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL %s_clear: got inf=%0d busy=%b a=%h b=%h rv=%b want all zero",
                            nm, bus.inflight, bus.busy, bus.mul_a, bus.mul_b, bus.rsp_valid);
        end
        model_reset();
        @(posedge clk);
        #1;
        total++;
        if (bus.inflight !== 4'd0 || bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL %s_hold: got inf=%0d rv=%b want 0 0", nm, bus.inflight, bus.rsp_valid);
        end
        #2 rst_n = 1'b1;
        for (int t = 0; t < STAGE + 4; t++) begin
            tick();
            total++;
            if (bus.rsp_valid !== 1'b0 || bus.rsp_y !== 16'd0) begin
                bad++; $display("FAIL %s_ghost: got rv=%b y=%0d want 0 0", nm, bus.rsp_valid, bus.rsp_y);
            end
        end
        v_in = 3'b111;
        tick();
        v_in = '0;
        total++;
        if (obs_ready !== 3'b001) begin bad++; $display("FAIL %s_first_grant: got %b want 001", nm, obs_ready); end
        while (q.size() != 0) begin
            tick();
            total++;
            if (bus.rsp_valid !== exp_rv || (exp_rv && (bus.rsp_id !== 2'(exp_id) || bus.rsp_y !== m_y))) begin
                bad++; $display("FAIL %s_drain: got rv=%b id=%0d y=%0d want rv=%b id=%0d y=%0d",
                                nm, bus.rsp_valid, bus.rsp_id, bus.rsp_y, exp_rv, exp_id, m_y);
            end
        end
    endtask

    task automatic test_random();
        string nm;
        nm = "random";
        for (int t = 0; t < 400 + STAGE + 1; t++) begin
            if (t % 20 == 0) en_in = 3'($urandom_range(1, 7));
            for (int i = 0; i < NREQ; i++) begin
                if (t >= 400) begin
                    v_in[i] = 1'b0;
                end else if (!v_in[i] || last_g == i) begin
                    if ($urandom_range(0, 3) != 0) begin
                        v_in[i] = 1'b1; a_in[i] = 8'($urandom); b_in[i] = 8'($urandom);
                    end else begin
                        v_in[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    v_in[i] = 1'b0;
                end
            end
            tick();
            total++;
            if (obs_ready !== exp_ready) begin bad++; $display("FAIL %s_ready: got %b want %b", nm, obs_ready, exp_ready); end
            total++;
            if (bus.rsp_valid !== exp_rv) begin bad++; $display("FAIL %s_rsp_valid: got %b want %b", nm, bus.rsp_valid, exp_rv); end
            if (exp_rv) begin
                total++;
                if (bus.rsp_id !== 2'(exp_id)) begin bad++; $display("FAIL %s_rsp_id: got %0d want %0d", nm, bus.rsp_id, exp_id); end
            end
            total++;
            if (bus.rsp_y !== m_y) begin bad++; $display("FAIL %s_rsp_y: got %0d want %0d", nm, bus.rsp_y, m_y); end
            total++;
            if (bus.inflight !== 4'(exp_inf) || bus.busy !== (exp_inf != 0)) begin
                bad++; $display("FAIL %s_inflight: got %0d/%b want %0d", nm, bus.inflight, bus.busy, exp_inf);
            end
            total++;
            if (bus.mul_a !== m_a || bus.mul_b !== m_b) begin
                bad++; $display("FAIL %s_mul_ops: got %h,%h want %h,%h", nm, bus.mul_a, bus.mul_b, m_a, m_b);
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        cyc    = 0;
        last_g = -1;
        v_in   = '0;
        en_in  = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_in[i] = '0; b_in[i] = '0;
        end
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_mask();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
